multi_channel_accumulator: RTL

Parametrised successor to the single-channel 8-bit accumulator. It holds NUM_CHANNELS independent unsigned accumulators of ACC_WIDTH bits, selectable per summand, with saturate or wrap overflow handling and sticky per-channel overflow flags. A valid/ready dump engine streams every channel's value out in channel order. It sits between sample producers (event counters, ADC front ends) and a downstream collector.

---
 rtl/multi_channel_accumulator.sv | 136 +++++++++++++
 1 files changed

// File: rtl/multi_channel_accumulator.sv
// NUM_CHANNELS independent unsigned accumulators with saturate/wrap overflow, sticky flags
// and a valid/ready dump engine. Define ACC_CLEAR_ON_DUMP_EN for read-and-clear dumping.
module multi_channel_accumulator #(
  parameter int DATA_WIDTH   = 8,
  parameter int ACC_WIDTH    = 16,
  parameter int NUM_CHANNELS = 4,
  parameter int SATURATE     = 1,
  localparam int CH_W        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                    i_CLK,
  input  logic                    i_RESET_N,
  input  logic                    i_CLK_EN,
  input  logic                    i_VALID,
  input  logic [CH_W-1:0]         i_CHANNEL,
  input  logic [DATA_WIDTH-1:0]   i_SUMMAND,
  input  logic                    i_CLEAR,
  input  logic                    i_DUMP,
  input  logic                    i_DUMP_READY,
  output logic                    o_BUSY,
  output logic                    o_DUMP_VALID,
  output logic [CH_W-1:0]         o_DUMP_CHANNEL,
  output logic [ACC_WIDTH-1:0]    o_DUMP_DATA,
  output logic [NUM_CHANNELS-1:0] o_OVERFLOW
);

  typedef enum logic {
    IDLE,
    DUMP
  } state_t;

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CHANNELS - 1);

  state_t                  state;
  state_t                  state_next;
  logic [CH_W-1:0]         dump_idx;
  logic [CH_W-1:0]         dump_idx_next;
  logic [ACC_WIDTH-1:0]    acc [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] overflow;
  logic                    in_range;
  logic                    do_accum;
  logic                    do_xfer;
  logic [ACC_WIDTH:0]      sum;
  logic [ACC_WIDTH-1:0]    sum_result;

  // The extra top bit of the sum is the carry that flags overflow.
  assign in_range   = ({1'b0, i_CHANNEL} < (CH_W + 1)'(NUM_CHANNELS));
  assign sum        = {1'b0, acc[i_CHANNEL]} + {{(ACC_WIDTH + 1 - DATA_WIDTH){1'b0}}, i_SUMMAND};
  assign sum_result = (sum[ACC_WIDTH] && (SATURATE != 0)) ? '1 : sum[ACC_WIDTH-1:0];

  assign o_BUSY         = (state == DUMP);
  assign o_DUMP_VALID   = (state == DUMP);
  assign o_DUMP_CHANNEL = dump_idx;
  assign o_DUMP_DATA    = acc[dump_idx];
  assign o_OVERFLOW     = overflow;

  always_comb begin
    state_next    = state;
    dump_idx_next = dump_idx;
    do_accum      = 1'b0;
    do_xfer       = 1'b0;
    if (i_CLEAR) begin
      state_next    = IDLE;
      dump_idx_next = '0;
    end else begin
      case (state)
        IDLE: begin
          do_accum = i_VALID && in_range;
          if (i_DUMP) begin
            state_next    = DUMP;
            dump_idx_next = '0;
          end
        end
        DUMP: begin
          if (i_DUMP_READY) begin
            do_xfer = 1'b1;
            if (dump_idx == LAST_CH) begin
              state_next    = IDLE;
              dump_idx_next = '0;
            end else begin
              dump_idx_next = dump_idx + 1'b1;
            end
          end
        end
        default: begin
          state_next    = IDLE;
          dump_idx_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      state    <= IDLE;
      dump_idx <= '0;
    end else if (i_CLK_EN) begin
      state    <= state_next;
      dump_idx <= dump_idx_next;
    end
  end

  // Accumulate and dump transfers never coincide: one happens only in IDLE, the other only in DUMP.
  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        acc[i] <= '0;
      end
      overflow <= '0;
    end else if (i_CLK_EN) begin
      if (i_CLEAR) begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
          acc[i] <= '0;
        end
        overflow <= '0;
      end else begin
        if (do_accum) begin
          acc[i_CHANNEL] <= sum_result;
          if (sum[ACC_WIDTH]) begin
            overflow[i_CHANNEL] <= 1'b1;
          end
        end
`ifdef ACC_CLEAR_ON_DUMP_EN
        if (do_xfer) begin
          acc[dump_idx]      <= '0;
          overflow[dump_idx] <= 1'b0;
        end
`else
        if (do_xfer) begin
          overflow <= overflow;
        end
`endif
      end
    end
  end

endmodule
